// File: rtl/mem_dmux_1m2s_pkg.sv
// Shared constants and types for the MemSplit32 one-master/two-slave demux.
package mem_dmux_1m2s_pkg;

    localparam logic [31:0] MEM_DMUX_S1_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] MEM_DMUX_S1_MASK_DEFAULT = 32'hF000_0000;

    typedef enum logic {
        TGT_S0 = 1'b0,
        TGT_S1 = 1'b1
    } tgt_e;

    function automatic tgt_e decode_tgt(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((addr & mask) == base) ? TGT_S1 : TGT_S0;
    endfunction

endpackage

// File: rtl/mem_dmux_1m2s_if.sv
// MemSplit32 split-transaction bus: request/ack from the initiator, resp/rdata later.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);
    modport Slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/mem_dmux_1m2s_rd_tracker.sv
// Counts in-flight reads and remembers which slave owns them.
//   state | meaning
//   IDLE  | r_cnt == 0, no reads outstanding
//   RD_S0 | r_cnt  > 0, reads in flight on slave 0
//   RD_S1 | r_cnt  > 0, reads in flight on slave 1
module mem_dmux_rd_tracker
    import mem_dmux_1m2s_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_rd_accept,
    input  tgt_e i_rd_tgt,
    input  logic i_resp,
    output logic o_busy,
    output logic o_full,
    output tgt_e o_owner
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] r_cnt;
    tgt_e          r_tgt;
    logic          w_ret;

    // A response only counts when reads are outstanding; late ones after reset are dropped.
    assign w_ret = i_resp && (r_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
            r_tgt <= TGT_S0;
        end else begin
            if (i_rd_accept && (r_cnt == '0))
                r_tgt <= i_rd_tgt;
            if (i_rd_accept && !w_ret && (r_cnt != C_MAX))
                r_cnt <= r_cnt + 1'b1;
            else if (!i_rd_accept && w_ret)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy  = (r_cnt != '0);
    assign o_full  = (r_cnt == C_MAX);
    assign o_owner = r_tgt;
endmodule

// File: rtl/mem_dmux_1m2s.sv
// Address-decoded demux from one MemSplit32 master to two slaves with in-order read returns.
module mem_dmux_1m2s
    import mem_dmux_1m2s_pkg::*;
#(
    parameter logic [31:0] S1_BASE         = MEM_DMUX_S1_BASE_DEFAULT,
    parameter logic [31:0] S1_MASK         = MEM_DMUX_S1_MASK_DEFAULT,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    MemSplit32.Slave  m,
    MemSplit32.Master s0,
    MemSplit32.Master s1
);
    tgt_e w_tgt;
    tgt_e w_owner;
    logic w_busy;
    logic w_full;
    logic w_fwd;
    logic w_sel0;
    logic w_sel1;
    logic w_rd_accept;
    logic w_resp_own;

    assign w_tgt = decode_tgt(m.addr, S1_BASE, S1_MASK);

    // Switching targets waits for the owner to drain so read data cannot reorder.
    assign w_fwd  = m.req && (!w_busy || ((w_tgt == w_owner) && (m.we || !w_full)));
    assign w_sel0 = w_fwd && (w_tgt == TGT_S0);
    assign w_sel1 = w_fwd && (w_tgt == TGT_S1);

    assign s0.req   = w_sel0;
    assign s0.we    = w_sel0 & m.we;
    assign s0.addr  = w_sel0 ? m.addr  : '0;
    assign s0.be    = w_sel0 ? m.be    : '0;
    assign s0.wdata = w_sel0 ? m.wdata : '0;

    assign s1.req   = w_sel1;
    assign s1.we    = w_sel1 & m.we;
    assign s1.addr  = w_sel1 ? m.addr  : '0;
    assign s1.be    = w_sel1 ? m.be    : '0;
    assign s1.wdata = w_sel1 ? m.wdata : '0;

    assign m.ack = (w_sel0 & s0.ack) | (w_sel1 & s1.ack);

    assign w_rd_accept = m.ack && !m.we;
    assign w_resp_own  = (w_owner == TGT_S1) ? s1.resp : s0.resp;

    assign m.resp  = w_busy & w_resp_own;
    assign m.rdata = !w_busy ? '0 : ((w_owner == TGT_S1) ? s1.rdata : s0.rdata);

    mem_dmux_rd_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_rd_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_rd_accept (w_rd_accept),
        .i_rd_tgt    (w_tgt),
        .i_resp      (w_resp_own),
        .o_busy      (w_busy),
        .o_full      (w_full),
        .o_owner     (w_owner)
    );
endmodule

// File: tb/tb_mem_dmux_1m2s.sv
// Bench for mem_dmux_1m2s: vector table for decode/steering plus read-ordering sequences.
module tb_mem_dmux_1m2s;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    MemSplit32 m_if ();
    MemSplit32 s0_if ();
    MemSplit32 s1_if ();

    mem_dmux_1m2s dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .m     (m_if.Slave),
        .s0    (s0_if.Master),
        .s1    (s1_if.Master)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        s0_ack;
        logic        s1_ack;
        logic        s0_resp;
        logic        s1_resp;
        logic        e_s0_req;
        logic        e_s1_req;
        logic        e_ack;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_in();
        m_if.req = 0; m_if.we = 0; m_if.addr = '0; m_if.be = '0; m_if.wdata = '0;
        s0_if.ack = 0; s0_if.resp = 0; s0_if.rdata = '0;
        s1_if.ack = 0; s1_if.resp = 0; s1_if.rdata = '0;
    endtask

    task automatic drive_m(input logic req, input logic we, input logic [31:0] addr);
        m_if.req = req; m_if.we = we; m_if.addr = addr; m_if.be = 4'hF; m_if.wdata = addr ^ 32'h5A5A_5A5A;
    endtask

    // Expected resp flag; when a response is expected its data comes off the scoreboard.
    task automatic check_resp(input string name, input logic exp_resp);
        logic [31:0] exp_d;
        check({name, ".resp"}, {31'b0, m_if.resp}, {31'b0, exp_resp});
        if (exp_resp) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL %s.sb: scoreboard empty, got rdata 0x%08h", name, m_if.rdata);
            end else begin
                exp_d = exp_q.pop_front();
                check({name, ".rdata"}, m_if.rdata, exp_d);
            end
        end else begin
            check({name, ".rdata0"}, m_if.rdata, 32'h0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 0, 1};
        vecs[1] = '{1, 1, 32'h8000_0020, 4'h3, 32'h0BAD_F00D, 0, 1, 0, 0, 0, 1, 1};
        vecs[2] = '{1, 1, 32'h8000_0020, 4'hC, 32'h1111_2222, 1, 0, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 0, 32'h9000_0000, 4'hF, 32'h0,         0, 0, 1, 0, 1, 0, 0};
        vecs[4] = '{1, 0, 32'h8FFF_FFFC, 4'h1, 32'h0,         0, 0, 0, 1, 0, 1, 0};
        vecs[5] = '{0, 1, 32'h8000_0000, 4'hF, 32'hCAFE_0000, 1, 1, 1, 1, 0, 0, 0};
        vecs[6] = '{1, 1, 32'h7FFF_FFFF, 4'h8, 32'h3333_4444, 1, 1, 0, 0, 1, 0, 1};
        vecs[7] = '{1, 0, 32'h0000_0000, 4'hF, 32'h0,         0, 1, 0, 1, 1, 0, 0};

        clear_in();
        rst_i = 0;
        tick(); tick();
        settle();
        check("rst.s0_req", {31'b0, s0_if.req}, 0);
        check("rst.s1_req", {31'b0, s1_if.req}, 0);
        check("rst.m_ack",  {31'b0, m_if.ack}, 0);
        check_resp("rst", 0);
        rst_i = 1;
        tick();

        // Writes and un-acked reads never change tracker state, so each vector starts in IDLE.
        for (int i = 0; i < 8; i++) begin
            m_if.req = vecs[i].req; m_if.we = vecs[i].we; m_if.addr = vecs[i].addr;
            m_if.be = vecs[i].be; m_if.wdata = vecs[i].wdata;
            s0_if.ack = vecs[i].s0_ack; s1_if.ack = vecs[i].s1_ack;
            s0_if.resp = vecs[i].s0_resp; s1_if.resp = vecs[i].s1_resp;
            s0_if.rdata = 32'hFFFF_FFFF; s1_if.rdata = 32'hFFFF_FFFF;
            settle();
            check($sformatf("v%0d.s0_req", i), {31'b0, s0_if.req}, {31'b0, vecs[i].e_s0_req});
            check($sformatf("v%0d.s1_req", i), {31'b0, s1_if.req}, {31'b0, vecs[i].e_s1_req});
            check($sformatf("v%0d.m_ack", i),  {31'b0, m_if.ack},  {31'b0, vecs[i].e_ack});
            check($sformatf("v%0d.s0_addr", i), s0_if.addr, vecs[i].e_s0_req ? vecs[i].addr : 32'h0);
            check($sformatf("v%0d.s1_addr", i), s1_if.addr, vecs[i].e_s1_req ? vecs[i].addr : 32'h0);
            check($sformatf("v%0d.s0_wdata", i), s0_if.wdata, vecs[i].e_s0_req ? vecs[i].wdata : 32'h0);
            check($sformatf("v%0d.s1_be", i), {28'b0, s1_if.be}, vecs[i].e_s1_req ? {28'b0, vecs[i].be} : 32'h0);
            check($sformatf("v%0d.s0_we", i), {31'b0, s0_if.we}, {31'b0, vecs[i].e_s0_req & vecs[i].we});
            check_resp($sformatf("v%0d", i), 0);
            tick();
            clear_in();
        end

        // Single s1 read, response two cycles after the ack.
        drive_m(1, 0, 32'h8000_0004); s1_if.ack = 1;
        settle();
        check("rd1.ack", {31'b0, m_if.ack}, 1);
        exp_q.push_back(32'h1234_5678);
        tick(); clear_in();
        settle(); check_resp("rd1.c1", 0);
        tick();
        s1_if.resp = 1; s1_if.rdata = 32'h1234_5678;
        settle(); check_resp("rd1.c2", 1);
        tick(); clear_in();
        drive_m(1, 0, 32'h0000_0100);
        settle();
        check("rd1.idle_s0_req", {31'b0, s0_if.req}, 1);
        tick(); clear_in();

        // s1 read in flight blocks an s0 read until the s1 response returns.
        drive_m(1, 0, 32'h8000_0008); s1_if.ack = 1;
        settle(); check("ord.s1_ack", {31'b0, m_if.ack}, 1);
        exp_q.push_back(32'hAAAA_0001);
        tick(); clear_in();
        for (int c = 0; c < 2; c++) begin
            drive_m(1, 0, 32'h0000_0000); s0_if.ack = 1;
            settle();
            check($sformatf("ord.stall%0d.s0_req", c), {31'b0, s0_if.req}, 0);
            check($sformatf("ord.stall%0d.ack", c), {31'b0, m_if.ack}, 0);
            tick();
        end
        s1_if.resp = 1; s1_if.rdata = 32'hAAAA_0001;
        settle();
        check_resp("ord.ret", 1);
        check("ord.ret.s0_req", {31'b0, s0_if.req}, 0);
        tick();
        s1_if.resp = 0; s1_if.rdata = '0;
        settle();
        check("ord.issue.s0_req", {31'b0, s0_if.req}, 1);
        check("ord.issue.ack", {31'b0, m_if.ack}, 1);
        exp_q.push_back(32'hBBBB_0002);
        tick(); clear_in();
        s0_if.resp = 1; s0_if.rdata = 32'hBBBB_0002;
        settle(); check_resp("ord.s0ret", 1);
        tick(); clear_in();

        // Fill to MAX_OUTSTANDING on s0, no bypass when full.
        for (int k = 0; k < 4; k++) begin
            drive_m(1, 0, 32'h0000_0200 + 32'(k * 4)); s0_if.ack = 1;
            settle();
            check($sformatf("full.rd%0d.ack", k), {31'b0, m_if.ack}, 1);
            exp_q.push_back(32'hC000_0000 + 32'(k));
            tick();
        end
        drive_m(1, 0, 32'h0000_0210); s0_if.ack = 1;
        settle();
        check("full.rd4.stall_ack", {31'b0, m_if.ack}, 0);
        check("full.rd4.stall_req", {31'b0, s0_if.req}, 0);
        tick();
        s0_if.resp = 1; s0_if.rdata = 32'hC000_0000;
        settle();
        check("full.nobypass.ack", {31'b0, m_if.ack}, 0);
        check_resp("full.ret0", 1);
        tick();
        s0_if.resp = 0; s0_if.rdata = '0;
        settle();
        check("full.rd4.ack", {31'b0, m_if.ack}, 1);
        exp_q.push_back(32'hC000_0004);
        tick();
        drive_m(1, 1, 32'h0000_0040); s0_if.ack = 1;
        settle(); check("full.wr_s0.ack", {31'b0, m_if.ack}, 1);
        tick();
        drive_m(1, 1, 32'h8000_0040); s0_if.ack = 1; s1_if.ack = 1;
        settle();
        check("busy.wr_s1.stall", {31'b0, s1_if.req}, 0);
        check("busy.wr_s1.ack", {31'b0, m_if.ack}, 0);
        tick(); clear_in();
        s1_if.resp = 1; s1_if.rdata = 32'hFFFF_FFFF;
        settle(); check_resp("spur.rd_s0", 0);
        tick(); clear_in();
        for (int k = 1; k <= 4; k++) begin
            s0_if.resp = 1; s0_if.rdata = 32'hC000_0000 + 32'(k);
            settle(); check_resp($sformatf("drain%0d", k), 1);
            tick(); clear_in();
        end
        drive_m(1, 1, 32'h8000_0044); s1_if.ack = 1;
        settle(); check("drained.wr_s1.ack", {31'b0, m_if.ack}, 1);
        tick(); clear_in();

        // Reset with s1 reads in flight drops tracking.
        for (int k = 0; k < 2; k++) begin
            drive_m(1, 0, 32'h8000_0300 + 32'(k * 4)); s1_if.ack = 1;
            settle(); check($sformatf("rst.s1rd%0d.ack", k), {31'b0, m_if.ack}, 1);
            tick();
        end
        clear_in();
        rst_i = 0;
        tick();
        rst_i = 1;
        s1_if.resp = 1; s1_if.rdata = 32'h5555_5555;
        drive_m(1, 0, 32'h0000_0400); s0_if.ack = 1;
        settle();
        check_resp("rst.late_s1", 0);
        check("rst.s0_issue.req", {31'b0, s0_if.req}, 1);
        check("rst.s0_issue.ack", {31'b0, m_if.ack}, 1);
        exp_q.push_back(32'hD00D_0001);
        tick(); clear_in();
        s0_if.resp = 1; s0_if.rdata = 32'hD00D_0001;
        settle(); check_resp("rst.s0_ret", 1);
        tick(); clear_in();

        check("sb.empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_dmux_1m2s.md
# mem_dmux_1m2s

Single-master, two-slave demultiplexer for the MemSplit32 split-transaction bus. It is the counterpart of the 2-master arbiter: one initiator, such as the arbiter's slave-side output or a core LSU, reaches two responders, for example tile RAM and an I/O window. Requests are steered by address decode. Outstanding reads are tracked so that read responses always return to the master in issue order.

## Interface
Parameters:
- S1_BASE, 32'h8000_0000, base address of slave 1 window
- S1_MASK, 32'hF000_0000, decode mask; slave 1 selected when (addr & S1_MASK) == S1_BASE, else slave 0
- MAX_OUTSTANDING, 4, maximum in-flight reads (1..15)

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset, synchronous, active-low
- m  MemSplit32.Slave  —  upstream master: req, we, addr[31:0], be[3:0], wdata[31:0] in; ack, resp, rdata[31:0] out
- s0  MemSplit32.Master  —  downstream slave 0 (default target)
- s1  MemSplit32.Master  —  downstream slave 1 (decoded window)

## Operation
- Target t = decode(m.addr), combinational.
- State: rd_cnt (clog2(MAX_OUTSTANDING+1) bits) and rd_tgt (1 bit, slave owning in-flight reads). Logical FSM:
  - IDLE: rd_cnt==0
  - RD_S0: rd_cnt>0, rd_tgt==0
  - RD_S1: rd_cnt>0, rd_tgt==1
- Issue permitted (forward) when m.req, and also one of the following:
  - IDLE, or
  - t==rd_tgt and (m.we or rd_cnt<MAX_OUTSTANDING).
- Any request (read or write) whose target differs from rd_tgt stalls while rd_cnt>0. This preserves ordering.
- Forward: s[t].req/we/addr/be/wdata = m.*, m.ack = s[t].ack. The non-selected slave sees req=0 and all other fields 0.
- Stall: both slaves req=0, m.ack=0. The master holds its request.
- Accepted read = forward and !m.we and s[t].ack.
  - From IDLE: rd_tgt <= t.
  - In all cases rd_cnt increments, unless a response is returned in the same cycle.
- Response path:
  - When rd_cnt>0: m.resp = s[rd_tgt].resp and m.rdata = s[rd_tgt].rdata.
  - When rd_cnt==0: m.resp=0 and m.rdata=0.
  - resp from the non-owning slave, or any resp while in IDLE, is ignored (no counter change).
- Counter update:
  - +1 on accepted read
  - −1 on returned resp
  - unchanged if both happen in the same cycle
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Transition back to IDLE occurs when the last response returns. rd_tgt is retained but is don't-care in IDLE.

## Timing
- Zero added latency: the request/ack path and the resp/rdata path are combinational through the block.
- New state is visible the cycle after an accepted read or returned response.
- A read accepted in cycle N with its resp also in cycle N is legal only if rd_cnt>0 beforehand (the resp belongs to an earlier read). Slaves respond no earlier than N+1 to their own reads.
- Reset (rst_i==0 at posedge): rd_cnt=0, rd_tgt=0. While rd_cnt==0 and m.req==0, all outputs are 0.
  - Reset mid-transaction drops the tracking; late responses after reset are ignored.
- Full (rd_cnt==MAX_OUTSTANDING): further reads stall, even if a resp arrives that cycle. There is no same-cycle bypass. Writes to rd_tgt still pass.

## Structure
- Shared package sigma_tile pkg/header provides:
  - MEM_DMUX_S1_BASE_DEFAULT and MEM_DMUX_S1_MASK_DEFAULT constants
  - the MemSplit32 interface (already present)
- One sub-module: mem_dmux_rd_tracker. It holds rd_cnt and rd_tgt, takes rd_accept, rd_tgt_in and resp_in, and outputs busy, full and owner.
- The top module holds the decode and muxing only.

## Test plan
- Write 0x0000_0010, be=4'hF, wdata=0xDEADBEEF, s0.ack=1 → s0 sees req with identical fields; s1.req=0; m.ack=1; rd_cnt stays 0.
- Read 0x8000_0004; s1 acks in cycle 0 and responds in cycle 2 with rdata=0x1234_5678 → m.resp=1 and m.rdata=0x1234_5678 in cycle 2; FSM returns to IDLE in cycle 3.
- Read to s1 in flight, then read to 0x0000_0000 (s0) → m.ack=0 and s0.req=0 until the s1 resp arrives. Issue to s0 occurs the cycle after the return to IDLE.
- Four back-to-back reads to s0 with no responses → fifth read stalls with rd_cnt=4. One resp returns → fifth read is accepted the next cycle.
- Spurious s1.resp=1 with rdata=0xFFFF_FFFF while in RD_S0 or IDLE → m.resp=0 and rd_cnt unchanged.
- Two reads to s1 accepted, then rst_i=0 for one cycle → rd_cnt=0. Subsequent s1.resp is not forwarded. A following s0 read issues immediately.
